// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared state encoding, widths and helpers for the router output-port arbiter
package router_pkg;

  localparam int ROUTER_DW = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_XFER = 2'd1
  } arb_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin picker
// Returns the first asserted request at or after ptr, wrapping past NPORTS-1.
module rr_priority_picker #(
  parameter int NPORTS = 4,
  parameter int IDX_W  = 2
) (
  input  logic [NPORTS-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic              found,
  output logic [IDX_W-1:0]  idx
);

  int               pos;
  logic [IDX_W-1:0] cand;

  // Walk from the farthest candidate back to ptr so the nearest request wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    cand  = '0;
    for (int k = NPORTS - 1; k >= 0; k--) begin
      pos  = (int'(ptr) + k) % NPORTS;
      cand = IDX_W'(pos);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/router_out_port_arbiter.sv
// rtl/router_out_port_arbiter.sv - packet-granular round-robin arbiter for one router output port
// Holds a grant from first word to eop; a mid-packet watchdog releases a stalled grant.
module router_out_port_arbiter
  import router_pkg::*;
#(
  parameter int NPORTS = 4,
  parameter int DW     = ROUTER_DW,
  parameter int IDX_W  = clog2(NPORTS),
  parameter int TMO    = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NPORTS-1:0]    fifo_empty,
  input  logic [NPORTS*DW-1:0] fifo_rdata,
  input  logic [NPORTS-1:0]    fifo_eop,
  output logic [NPORTS-1:0]    fifo_rinc,
  output logic [DW-1:0]        out_data,
  output logic                 out_valid,
  output logic                 out_eop,
  input  logic                 out_ready,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 busy,
  output logic                 err_tmo
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [7:0]       tmo_cnt_q, tmo_cnt_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_eop_q, out_eop_d;

  logic [NPORTS-1:0] fifo_req;
  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;
  logic              head_empty;
  logic              head_eop;
  logic [DW-1:0]     head_data;
  logic [IDX_W-1:0]  after_grant;
  logic              pop;
  logic              tmo_hit;

  assign fifo_req = ~fifo_empty;

  rr_priority_picker #(
    .NPORTS(NPORTS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req  (fifo_req),
    .ptr  (rr_ptr_q),
    .found(pick_found),
    .idx  (pick_idx)
  );

  assign head_empty  = fifo_empty[grant_q];
  assign head_eop    = fifo_eop[grant_q];
  assign head_data   = fifo_rdata[grant_q*DW +: DW];
  assign after_grant = (grant_q == IDX_W'(NPORTS - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    tmo_cnt_d   = tmo_cnt_q;
    out_data_d  = out_data_q;
    out_eop_d   = out_eop_q;
    out_valid_d = out_valid_q;
    tmo_hit     = 1'b0;
    pop         = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_d   = pick_idx;
          tmo_cnt_d = '0;
          state_d   = ARB_XFER;
        end
      end
      ARB_XFER: begin
        // The watchdog wins over a late-arriving word: the packet is already truncated.
        tmo_hit = (tmo_cnt_q == 8'(TMO));
        pop     = !tmo_hit && !head_empty && (!out_valid_q || out_ready);
        if (tmo_hit) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = after_grant;
        end else if (pop) begin
          tmo_cnt_d = '0;
          if (head_eop) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = after_grant;
          end
        end else if (head_empty) begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    if (pop) begin
      out_data_d  = head_data;
      out_eop_d   = head_eop;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    fifo_rinc = pop ? (NPORTS'(1) << grant_q) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      tmo_cnt_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_eop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      tmo_cnt_q   <= tmo_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_eop_q   <= out_eop_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_eop   = out_eop_q;
  assign grant_idx = grant_q;
  assign busy      = (state_q == ARB_XFER);
  assign err_tmo   = tmo_hit;

endmodule

// File: tb/tb_router_out_port_arbiter.sv
// tb/tb_router_out_port_arbiter.sv - self-checking bench with queue-based FIFOs and a packet-level reference model
module tb_router_out_port_arbiter;

  localparam int NP  = 4;
  localparam int DW  = 8;
  localparam int IW  = 2;
  localparam int TMO = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP-1:0]    fifo_empty;
  logic [NP*DW-1:0] fifo_rdata;
  logic [NP-1:0]    fifo_eop;
  logic [NP-1:0]    fifo_rinc;
  logic [DW-1:0]    out_data;
  logic             out_valid;
  logic             out_eop;
  logic             out_ready;
  logic [IW-1:0]    grant_idx;
  logic             busy;
  logic             err_tmo;

  always #5 clk = ~clk;

  router_out_port_arbiter #(
    .NPORTS(NP),
    .DW    (DW),
    .IDX_W (IW),
    .TMO   (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata),
    .fifo_eop  (fifo_eop),
    .fifo_rinc (fifo_rinc),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_eop   (out_eop),
    .out_ready (out_ready),
    .grant_idx (grant_idx),
    .busy      (busy),
    .err_tmo   (err_tmo)
  );

  // Each FIFO entry is {eop, data}
  logic [DW:0] fq [NP][$];
  logic [DW:0] exp_words [$];

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  bit          m_xfer, m_ov, m_oe;
  logic [DW-1:0] m_od;
  int          m_g, m_ptr, m_tmo, m_pop_port;

  bit prev_busy;
  int grant_log [$];
  int grant_cyc [$];
  int acc_log [$];
  int last_pop_cyc, err_cnt, err_gap, rinc_cnt;
  int valid_cnt, valid_first, valid_last;
  int pushed_total;
  int t0, snap, n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic int glog(input int i);
    return (i < grant_log.size()) ? grant_log[i] : -1;
  endfunction

  function automatic int gcyc(input int i);
    return (i < grant_cyc.size()) ? grant_cyc[i] : -1;
  endfunction

  function automatic int alog(input int i);
    return (i < acc_log.size()) ? acc_log[i] : -1;
  endfunction

  function automatic void drive_fifos();
    for (int i = 0; i < NP; i++) begin
      if (fq[i].size() > 0) begin
        fifo_empty[i]            = 1'b0;
        fifo_eop[i]              = fq[i][0][DW];
        fifo_rdata[i*DW +: DW]   = fq[i][0][DW-1:0];
      end else begin
        fifo_empty[i]            = 1'b1;
        fifo_eop[i]              = 1'b0;
        fifo_rdata[i*DW +: DW]   = '0;
      end
    end
  endfunction

  task automatic push_pkt(input int p, input int len, input bit with_eop);
    for (int k = 0; k < len; k++) begin
      fq[p].push_back({(with_eop && (k == len - 1)), DW'($urandom)});
      pushed_total++;
    end
  endtask

  task automatic clear_logs();
    grant_log.delete();
    grant_cyc.delete();
    acc_log.delete();
    valid_cnt = 0;
    valid_first = -1;
    valid_last = -1;
  endtask

  task automatic model_reset();
    m_xfer = 0; m_ov = 0; m_oe = 0; m_od = '0;
    m_g = 0; m_ptr = 0; m_tmo = 0; m_pop_port = -1;
    prev_busy = 0;
    for (int i = 0; i < NP; i++) fq[i].delete();
  endtask

  // Compare DUT against the model for the current cycle, log observations, then advance the model.
  task automatic step();
    bit fire, pop;
    int exp_rinc;
    fire = m_xfer && (m_tmo == TMO);
    pop = m_xfer && !fire && (fq[m_g].size() > 0) && (!m_ov || out_ready);
    exp_rinc = pop ? (1 << m_g) : 0;

    check("busy", 32'(busy), 32'(m_xfer));
    check("grant_idx", 32'(grant_idx), 32'(m_g));
    check("out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      check("out_data", 32'(out_data), 32'(m_od));
      check("out_eop", 32'(out_eop), 32'(m_oe));
    end
    check("err_tmo", 32'(err_tmo), 32'(fire));
    check("fifo_rinc", 32'(fifo_rinc), 32'(exp_rinc));

    if (busy && !prev_busy) begin
      grant_log.push_back(int'(grant_idx));
      grant_cyc.push_back(cyc);
    end
    prev_busy = busy;
    if (fifo_rinc != '0) begin
      last_pop_cyc = cyc;
      rinc_cnt++;
    end
    if (err_tmo) begin
      err_cnt++;
      err_gap = cyc - last_pop_cyc;
    end
    if (out_valid) begin
      if (valid_cnt == 0) valid_first = cyc;
      valid_last = cyc;
      valid_cnt++;
    end
    if (out_valid && out_ready) acc_log.push_back(int'(out_data));

    if (pop) begin
      {m_oe, m_od} = fq[m_g][0];
      m_ov = 1;
    end else if (out_ready) begin
      m_ov = 0;
    end
    m_pop_port = pop ? m_g : -1;

    if (!m_xfer) begin
      for (int k = 0; k < NP; k++) begin
        int p;
        p = (m_ptr + k) % NP;
        if (fq[p].size() > 0) begin
          m_g = p;
          m_xfer = 1;
          m_tmo = 0;
          break;
        end
      end
    end else if (fire || (pop && fq[m_g][0][DW])) begin
      m_xfer = 0;
      m_ptr = (m_g + 1) % NP;
    end else if (pop) begin
      m_tmo = 0;
    end else if (fq[m_g].size() == 0) begin
      m_tmo++;
    end
  endtask

  task automatic cycle();
    drive_fifos();
    @(negedge clk);
    step();
    @(posedge clk);
    #1;
    cyc++;
    if (m_pop_port >= 0) void'(fq[m_pop_port].pop_front());
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) cycle();
  endtask

  // Entered at posedge+1; asserts reset mid-cycle and checks outputs without waiting for a clock.
  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_eop", 32'(out_eop), 32'd0);
    check("rst_grant_idx", 32'(grant_idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err_tmo", 32'(err_tmo), 32'd0);
    check("rst_fifo_rinc", 32'(fifo_rinc), 32'd0);
    model_reset();
    drive_fifos();
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    err_cnt = 0; err_gap = -1; rinc_cnt = 0; last_pop_cyc = 0; pushed_total = 0;
    model_reset();
    clear_logs();
    drive_fifos();
    do_reset();

    // Single 3-word packet on port 2
    clear_logs();
    fq[2].push_back({1'b0, 8'hA0});
    fq[2].push_back({1'b0, 8'hA1});
    fq[2].push_back({1'b1, 8'hA2});
    t0 = cyc;
    run(8);
    check("t1_grant", 32'(glog(0)), 32'd2);
    check("t1_grant_latency", 32'(gcyc(0) - t0), 32'd1);
    check("t1_valid_cnt", 32'(valid_cnt), 32'd3);
    check("t1_valid_span", 32'(valid_last - valid_first), 32'd2);
    check("t1_w0", 32'(alog(0)), 32'h A0);
    check("t1_w2", 32'(alog(2)), 32'h A2);
    push_pkt(0, 1, 1);
    push_pkt(3, 1, 1);
    run(8);
    check("t1_next_is_3", 32'(glog(1)), 32'd3);
    check("t1_then_0", 32'(glog(2)), 32'd0);

    // Round robin over four 1-word packets plus a second one on port 0
    do_reset();
    clear_logs();
    for (int p = 0; p < NP; p++) push_pkt(p, 1, 1);
    push_pkt(0, 1, 1);
    run(14);
    check("rr_count", 32'(grant_log.size()), 32'd5);
    for (int i = 0; i < 5; i++) check("rr_order", 32'(glog(i)), 32'(i % NP));
    for (int i = 1; i < 5; i++) check("rr_spacing", 32'(gcyc(i) - gcyc(i - 1)), 32'd2);

    // Backpressure mid-packet on port 1
    clear_logs();
    push_pkt(1, 6, 1);
    exp_words = fq[1];
    run(3);
    out_ready = 1'b0;
    snap = rinc_cnt;
    n = err_cnt;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("bp_hold_data", 32'(out_data), 32'(exp_words[1][DW-1:0]));
      check("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    check("bp_no_pop", 32'(rinc_cnt - snap), 32'd0);
    out_ready = 1'b1;
    run(10);
    check("bp_no_err", 32'(err_cnt - n), 32'd0);
    check("bp_count", 32'(acc_log.size()), 32'd6);
    for (int i = 0; i < 6; i++) check("bp_word", 32'(alog(i)), 32'(exp_words[i][DW-1:0]));

    // Mid-packet starvation on port 1
    clear_logs();
    n = err_cnt;
    push_pkt(1, 2, 0);
    run(4);
    push_pkt(2, 1, 1);
    push_pkt(3, 1, 1);
    run(30);
    check("tmo_pulses", 32'(err_cnt - n), 32'd1);
    check("tmo_gap", 32'(err_gap), 32'(TMO + 1));
    check("tmo_first", 32'(glog(0)), 32'd1);
    check("tmo_next", 32'(glog(1)), 32'd2);

    // Async reset in the middle of a port 3 packet
    clear_logs();
    push_pkt(3, 5, 1);
    run(3);
    check("ar_busy_before", 32'(busy), 32'd1);
    check("ar_valid_before", 32'(out_valid), 32'd1);
    do_reset();
    clear_logs();
    push_pkt(2, 1, 1);
    push_pkt(0, 1, 1);
    run(8);
    check("ar_restart_0", 32'(glog(0)), 32'd0);
    check("ar_then_2", 32'(glog(1)), 32'd2);

    // Port 3 appears in the cycle port 0 pops its eop
    for (int v = 0; v < 2; v++) begin
      do_reset();
      clear_logs();
      push_pkt(0, 2, 1);
      n = 0;
      while (!(m_xfer && m_g == 0 && fq[0].size() == 1) && n < 20) begin
        cycle();
        n++;
      end
      check("sim_reach", 32'(n < 20), 32'd1);
      push_pkt(3, 1, 1);
      if (v == 1) push_pkt(2, 1, 1);
      run(10);
      check("sim_first", 32'(glog(0)), 32'd0);
      check("sim_next", 32'(glog(1)), (v == 1) ? 32'd2 : 32'd3);
    end

    // Random traffic
    do_reset();
    clear_logs();
    pushed_total = 0;
    for (int i = 0; i < 2000; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) begin
        int p;
        p = int'($urandom_range(0, NP - 1));
        if (fq[p].size() < 6) push_pkt(p, int'($urandom_range(1, 4)), ($urandom_range(0, 19) != 0));
      end
      cycle();
    end
    out_ready = 1'b1;
    n = 0;
    while ((fq[0].size() + fq[1].size() + fq[2].size() + fq[3].size() > 0 || m_xfer || m_ov) && n < 400) begin
      cycle();
      n++;
    end
    check("rand_drained", 32'(n < 400), 32'd1);
    check("rand_words", 32'(acc_log.size()), 32'(pushed_total));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
